// File: rtl/cpu_pkg.sv
// Shared constants and types for the RAM port A arbiter.
package cpu_pkg;

  // Which requester was granted most recently
  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DBG = 1'b1
  } owner_e;

  localparam int          RAM_AW  = 9;
  localparam logic [3:0]  WE_NONE = 4'b0000;

endpackage

// File: rtl/arb_rr2.sv
// Two-way round-robin arbiter with a debug lock bounded by a burst limit.
// req[0]/gnt[0] belong to the cpu, req[1]/gnt[1] to the debug port.
module arb_rr2
  import cpu_pkg::*;
#(
  parameter int MAX_BURST = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       lock,
  output logic [1:0] gnt
);

  localparam logic [7:0] BURST_MAX = 8'(MAX_BURST);

  owner_e     last_owner;
  logic [7:0] burst_cnt;
  logic       keep_dbg;

  assign keep_dbg = (last_owner == OWN_DBG) && lock && (burst_cnt < BURST_MAX);

  // Grant decision: single requester wins, contention resolved by lock or round-robin
  always_comb begin
    gnt = 2'b00;
    if (req == 2'b11) begin
      if (keep_dbg || (last_owner == OWN_CPU)) gnt = 2'b10;
      else                                     gnt = 2'b01;
    end else begin
      gnt = req;
    end
  end

  // Owner history and count of dbg grants taken while the cpu was waiting
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_owner <= OWN_CPU;
      burst_cnt  <= 8'd0;
    end else begin
      if (gnt[1])      last_owner <= OWN_DBG;
      else if (gnt[0]) last_owner <= OWN_CPU;

      if (gnt[1] && req[0]) begin
        if (burst_cnt >= BURST_MAX) burst_cnt <= BURST_MAX;
        else                        burst_cnt <= burst_cnt + 8'd1;
      end else if (gnt[0] || !req[0]) begin
        burst_cnt <= 8'd0;
      end
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares RAM port A between the memory stage (cpu) and a debug/boot loader (dbg).
// Grants are combinational and reach the RAM in the same cycle; read data returns
// one cycle later and is flagged by the matching rvalid.
module ram_port_arbiter
  import cpu_pkg::*;
#(
  parameter int AW        = RAM_AW,
  parameter int DW        = 32,
  parameter int MAX_BURST = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic [3:0]    cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_stall,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
  input  logic          dbg_req,
  input  logic [3:0]    dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  input  logic          dbg_lock,
  output logic          dbg_gnt,
  output logic          dbg_rvalid,
  output logic [DW-1:0] dbg_rdata,
  output logic [3:0]    ram_we_a,
  output logic [AW-1:0] ram_addr_a,
  output logic [DW-1:0] ram_wdata_a,
  input  logic [DW-1:0] ram_rdata_a
);

  logic [1:0] req_masked;
  logic [1:0] gnt;
  logic       rvalid_cpu;
  logic       rvalid_dbg;

  // Requests are masked during reset so nothing reaches the RAM
  assign req_masked = {dbg_req, cpu_req} & {2{~rst}};

  arb_rr2 #(
    .MAX_BURST (MAX_BURST)
  ) u_arb (
    .clk  (clk),
    .rst  (rst),
    .req  (req_masked),
    .lock (dbg_lock),
    .gnt  (gnt)
  );

  assign cpu_gnt    = gnt[0];
  assign dbg_gnt    = gnt[1];
  assign cpu_stall  = cpu_req & ~cpu_gnt;
  assign cpu_rdata  = ram_rdata_a;
  assign dbg_rdata  = ram_rdata_a;
  assign cpu_rvalid = rvalid_cpu;
  assign dbg_rvalid = rvalid_dbg;

  // Route the winner's access to port A; idle port is driven to zero
  always_comb begin
    ram_we_a    = WE_NONE;
    ram_addr_a  = '0;
    ram_wdata_a = '0;
    if (cpu_gnt) begin
      ram_we_a    = cpu_we;
      ram_addr_a  = cpu_addr;
      ram_wdata_a = cpu_wdata;
    end else if (dbg_gnt) begin
      ram_we_a    = dbg_we;
      ram_addr_a  = dbg_addr;
      ram_wdata_a = dbg_wdata;
    end
  end

  // Flag read data one cycle after a read grant; reset discards a pending read
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rvalid_cpu <= 1'b0;
      rvalid_dbg <= 1'b0;
    end else begin
      rvalid_cpu <= cpu_gnt && (cpu_we == WE_NONE);
      rvalid_dbg <= dbg_gnt && (dbg_we == WE_NONE);
    end
  end

endmodule
